// File: rtl/i2osp_stream_pkg.sv
// Shared definitions for the I2OSP octet-stream stage: octet width, FSM
// encoding and default sizing. OS2IP and the padding stage import these as well.
package i2osp_stream_pkg;

  localparam int OCTET_W                = 8;
  localparam int DEFAULT_DATA_BIT_WIDTH = 2048;
  localparam int DEFAULT_XLEN           = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/i2osp_stream_if.sv
// Handshake bundle between the integer producer (master), the I2OSP stage
// (slave) and the downstream octet consumer.
interface i2osp_stream_if #(
  parameter int DATA_BIT_WIDTH = 2048
);
  import i2osp_stream_pkg::*;

  logic                      valid;
  logic [DATA_BIT_WIDTH-1:0] x;
  logic                      in_ready;
  logic [OCTET_W-1:0]        o_data;
  logic                      o_valid;
  logic                      o_ready;
  logic                      o_last;
  logic                      o_error;
  logic                      busy;

  modport master (
    output valid, x, o_ready,
    input  in_ready, o_data, o_valid, o_last, o_error, busy
  );

  modport slave (
    input  valid, x, o_ready,
    output in_ready, o_data, o_valid, o_last, o_error, busy
  );

endinterface

// File: rtl/i2osp_stream.sv
// I2OSP stage: turns a nonnegative integer into an XLEN-octet big-endian
// string and streams it one octet per valid/ready handshake. Integers that do
// not fit in XLEN octets produce a single-cycle error pulse and no octets.
module i2osp_stream
  import i2osp_stream_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = DEFAULT_DATA_BIT_WIDTH,
  parameter int XLEN           = DEFAULT_XLEN
) (
  input  logic          clk,
  input  logic          reset_n,
  i2osp_stream_if.slave bus
);

  localparam int                WIN_W    = OCTET_W * XLEN;
  localparam int                CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(XLEN - 1);

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               too_large_s;
  logic               hs_s;
  logic               last_s;

  // Overflow only exists when the window is narrower than the input integer.
  generate
    if (WIN_W < DATA_BIT_WIDTH) begin : g_range_chk
      assign too_large_s = |bus.x[DATA_BIT_WIDTH-1:WIN_W];
    end else begin : g_no_range_chk
      assign too_large_s = 1'b0;
    end
  endgenerate

  assign hs_s   = (state_q == ST_SEND) && bus.o_ready;
  assign last_s = (cnt_q == LAST_CNT);

  // State, shift window and octet counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decision: accept in IDLE, leave SEND after the final handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          state_d = too_large_s ? ST_ERR : ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (hs_s && last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Window load on accept, octet shift and count on every handshake.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid) begin
          // Oversized integers are dropped; the window stays clear.
          shreg_d = too_large_s ? '0 : bus.x[WIN_W-1:0];
          cnt_d   = '0;
        end else begin
          shreg_d = shreg_q;
          cnt_d   = cnt_q;
        end
      end
      ST_SEND: begin
        if (hs_s) begin
          shreg_d = shreg_q << OCTET_W;
          cnt_d   = last_s ? '0 : cnt_q + CNT_W'(1);
        end else begin
          shreg_d = shreg_q;
          cnt_d   = cnt_q;
        end
      end
      ST_ERR: begin
        shreg_d = '0;
        cnt_d   = '0;
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode straight from registered state, so outputs are glitch-free.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.o_valid  = 1'b0;
    bus.o_last   = 1'b0;
    bus.o_error  = 1'b0;
    bus.busy     = 1'b0;
    bus.o_data   = shreg_q[WIN_W-1 -: OCTET_W];
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
      end
      ST_SEND: begin
        bus.o_valid = 1'b1;
        bus.busy    = 1'b1;
        bus.o_last  = last_s;
      end
      ST_ERR: begin
        bus.o_error = 1'b1;
        bus.busy    = 1'b1;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_i2osp_stream.sv
// Bench for i2osp_stream: a small instance (64-bit integer, 4 octets) checked
// every cycle against a queue-based model, plus a full-size instance
// (2048-bit, 256 octets) checked by reassembling its output stream.
module tb_i2osp_stream;

  localparam int DW_S = 64;
  localparam int XL_S = 4;
  localparam int DW_B = 2048;
  localparam int XL_B = 256;

  logic clk;
  logic reset_n;

  i2osp_stream_if #(.DATA_BIT_WIDTH(DW_S)) if_s ();
  i2osp_stream_if #(.DATA_BIT_WIDTH(DW_B)) if_b ();

  i2osp_stream #(.DATA_BIT_WIDTH(DW_S), .XLEN(XL_S)) u_small (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_s)
  );

  i2osp_stream #(.DATA_BIT_WIDTH(DW_B), .XLEN(XL_B)) u_big (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- small-instance reference model ----------------
  // Pending octets of the accepted integer, front = octet on the bus now.
  logic [7:0] exp_q[$];
  bit         err_pend = 1'b0;

  always @(posedge clk) begin
    logic [DW_S-1:0] xv;
    if (!reset_n) begin
      exp_q.delete();
      err_pend = 1'b0;
    end else if (err_pend) begin
      err_pend = 1'b0;
    end else if (exp_q.size() != 0) begin
      if (if_s.o_ready) void'(exp_q.pop_front());
    end else if (if_s.valid) begin
      xv = if_s.x;
      if ((xv >> (8 * XL_S)) != 0) err_pend = 1'b1;
      else for (int i = 0; i < XL_S; i++) exp_q.push_back(xv[8*(XL_S-1-i) +: 8]);
    end
  end

  // Per-cycle comparison of the small instance against the model.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      chk("s_o_valid",  if_s.o_valid, 1);
      chk("s_o_data",   if_s.o_data, exp_q[0]);
      chk("s_o_last",   if_s.o_last, (exp_q.size() == 1) ? 1 : 0);
      chk("s_in_ready", if_s.in_ready, 0);
      chk("s_o_error",  if_s.o_error, 0);
      chk("s_busy",     if_s.busy, 1);
    end else if (err_pend) begin
      chk("s_o_error",  if_s.o_error, 1);
      chk("s_o_valid",  if_s.o_valid, 0);
      chk("s_in_ready", if_s.in_ready, 0);
      chk("s_busy",     if_s.busy, 1);
    end else begin
      chk("s_o_valid",  if_s.o_valid, 0);
      chk("s_o_error",  if_s.o_error, 0);
      chk("s_in_ready", if_s.in_ready, 1);
      chk("s_busy",     if_s.busy, 0);
    end
  end

  // Handshake logs used by the hand-computed scenario checks.
  logic [7:0] hs_log[$];
  bit         hs_last[$];
  int         err_cnt_s = 0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (if_s.o_valid && if_s.o_ready) begin
        hs_log.push_back(if_s.o_data);
        hs_last.push_back(if_s.o_last);
      end
      if (if_s.o_error) err_cnt_s++;
    end
  end

  // o_ready pattern for the small instance: 0 always, 1 pattern 1,0,0,1, 2 random.
  int rdy_mode = 0;
  int rdy_cyc  = 0;
  always @(negedge clk) begin
    case (rdy_mode)
      1:       if_s.o_ready = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
      2:       if_s.o_ready = ($urandom_range(0, 3) != 0);
      default: if_s.o_ready = 1'b1;
    endcase
    rdy_cyc++;
  end

  // ---------------- big-instance monitor (OS2IP reassembly) ----------------
  logic [DW_B-1:0] rt_b;
  int              oct_cnt_b  = 0;
  int              last_cnt_b = 0;
  int              err_cnt_b  = 0;
  int              bubble_b   = 0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (if_b.o_valid && if_b.o_ready) begin
        rt_b = {rt_b[DW_B-9:0], if_b.o_data};
        oct_cnt_b++;
        if (if_b.o_last) last_cnt_b++;
      end
      if (if_b.o_error) err_cnt_b++;
      if (if_b.busy && !if_b.o_valid) bubble_b++;
    end
  end

  task automatic chk_wide(input string name, input logic [DW_B-1:0] act, input logic [DW_B-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got low64 %0h expected low64 %0h", name, act[63:0], exp[63:0]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_s(input logic [DW_S-1:0] v);
    @(negedge clk);
    if_s.valid = 1'b1;
    if_s.x     = v;
    @(negedge clk);
    if_s.valid = 1'b0;
  endtask

  task automatic wait_idle_s(input int max_cyc, output int n);
    n = 0;
    while (!if_s.in_ready && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("s_idle_timeout", if_s.in_ready, 1);
  endtask

  task automatic send_b(input logic [DW_B-1:0] v, output int n);
    @(negedge clk);
    rt_b = '0; oct_cnt_b = 0; last_cnt_b = 0; bubble_b = 0;
    if_b.valid = 1'b1;
    if_b.x     = v;
    @(negedge clk);
    if_b.valid = 1'b0;
    n = 0;
    while (!if_b.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle_timeout", if_b.in_ready, 1);
  endtask

  logic [7:0] t1_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] t4_exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] t6_exp [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4};

  initial begin
    int n;
    int e0;
    int guard;
    logic [DW_S-1:0] xs;
    logic [DW_B-1:0] xb;

    reset_n    = 1'b0;
    if_s.valid = 1'b0; if_s.x = '0;
    if_b.valid = 1'b0; if_b.x = '0; if_b.o_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", if_s.in_ready, 1);
    chk("rst_o_data",   if_s.o_data, 0);
    chk("rst_busy",     if_s.busy, 0);
    chk("rst_big_rdy",  if_b.in_ready, 1);

    // T1: plain stream, o_ready high.
    rdy_mode = 0;
    hs_log.delete(); hs_last.delete();
    send_s(64'h0000_0000_1122_3344);
    wait_idle_s(20, n);
    chk("t1_cycles", n, 4);
    chk("t1_count", hs_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_octet", hs_log[i], t1_exp[i]);
      chk("t1_last",  hs_last[i], (i == 3) ? 1 : 0);
    end

    // T2: integer wider than 4 octets.
    hs_log.delete(); hs_last.delete();
    e0 = err_cnt_s;
    send_s(64'h0000_0001_0000_0000);
    wait_idle_s(20, n);
    chk("t2_cycles", n, 1);
    chk("t2_err_pulses", err_cnt_s - e0, 1);
    chk("t2_no_octets", hs_log.size(), 0);

    // T3: stalls with o_ready pattern 1,0,0,1.
    rdy_mode = 1; rdy_cyc = 0;
    hs_log.delete(); hs_last.delete();
    send_s(64'h0000_0000_1122_3344);
    wait_idle_s(40, n);
    chk("t3_count", hs_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_octet", hs_log[i], t1_exp[i]);

    // T4: reset after the second octet, then a fresh integer.
    rdy_mode = 0;
    hs_log.delete(); hs_last.delete();
    send_s(64'h0000_0000_1122_3344);
    guard = 0;
    while (hs_log.size() < 2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("t4_two_sent", hs_log.size(), 2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t4_valid_low", if_s.o_valid, 0);
    chk("t4_data_zero", if_s.o_data, 0);
    reset_n = 1'b1;
    hs_log.delete(); hs_last.delete();
    send_s(64'h0000_0000_AABB_CCDD);
    wait_idle_s(20, n);
    chk("t4_count", hs_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_octet", hs_log[i], t4_exp[i]);

    // T6: valid held high with a new x during SEND.
    hs_log.delete(); hs_last.delete();
    @(negedge clk);
    if_s.valid = 1'b1; if_s.x = 64'h0000_0000_0102_0304;
    @(negedge clk);
    if_s.x = 64'h0000_0000_A1B2_C3D4;
    wait_idle_s(20, n);
    @(negedge clk);
    if_s.valid = 1'b0;
    wait_idle_s(20, n);
    chk("t6_count", hs_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("t6_octet", hs_log[i], t6_exp[i]);

    // Random traffic under random back-pressure, checked by the model.
    rdy_mode = 2;
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xs = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) != 0) xs[63:32] = 32'h0;
      send_s(xs);
      wait_idle_s(100, n);
    end
    rdy_mode = 0;

    // T5: full-size instance, zero then all-ones, then random round trips.
    send_b('0, n);
    chk("t5z_cycles",  n, 256);
    chk("t5z_octets",  oct_cnt_b, 256);
    chk("t5z_last",    last_cnt_b, 1);
    chk("t5z_bubbles", bubble_b, 0);
    chk_wide("t5z_value", rt_b, '0);
    send_b({DW_B{1'b1}}, n);
    chk("t5f_octets",  oct_cnt_b, 256);
    chk("t5f_last",    last_cnt_b, 1);
    chk_wide("t5f_value", rt_b, {DW_B{1'b1}});
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < DW_B / 32; w++) xb[32*w +: 32] = $urandom();
      send_b(xb, n);
      chk("t5r_octets", oct_cnt_b, 256);
      chk_wide("t5r_roundtrip", rt_b, xb);
    end
    chk("t5_no_error", err_cnt_b, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
